// File: rtl/simon_pkg.sv
// Shared Simon128/256 definitions: round count, word width, decrypt FSM states
// and the round-function helpers used by both the encrypt and decrypt cores.
// Purely declarative; no logic of its own.
package simon_pkg;

  localparam int SIMON128_256_ROUNDS = 72;
  localparam int SIMON_WORD          = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } simon_dec_state_t;

  function automatic logic [SIMON_WORD-1:0] rol1(input logic [SIMON_WORD-1:0] v);
    return {v[SIMON_WORD-2:0], v[SIMON_WORD-1]};
  endfunction

  function automatic logic [SIMON_WORD-1:0] rol2(input logic [SIMON_WORD-1:0] v);
    return {v[SIMON_WORD-3:0], v[SIMON_WORD-1:SIMON_WORD-2]};
  endfunction

  function automatic logic [SIMON_WORD-1:0] rol8(input logic [SIMON_WORD-1:0] v);
    return {v[SIMON_WORD-9:0], v[SIMON_WORD-1:SIMON_WORD-8]};
  endfunction

  // f(v) = (rol1(v) & rol8(v)) ^ rol2(v)
  function automatic logic [SIMON_WORD-1:0] simon_f(input logic [SIMON_WORD-1:0] v);
    return (rol1(v) & rol8(v)) ^ rol2(v);
  endfunction

endpackage

// File: rtl/simon128_dec_round.sv
// One Simon128 inverse round: (x, y, k) -> (y, x ^ f(y) ^ k).
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is registered.
module simon128_dec_round
  import simon_pkg::*;
(
  input  logic [SIMON_WORD-1:0] x,
  input  logic [SIMON_WORD-1:0] y,
  input  logic [SIMON_WORD-1:0] k,
  output logic [SIMON_WORD-1:0] x_next,
  output logic [SIMON_WORD-1:0] y_next
);

  assign x_next = y;
  assign y_next = x ^ simon_f(y) ^ k;

endmodule

// File: rtl/simon128_256_decrypt.sv
// Iterative Simon128/256 decryption: one inverse round per returned round key, keys 71..0.
// Latency: 74 cycles from acceptance to pt_vld with a 1-cycle key memory; slower memory stretches it.
// Backpressure: ct_rdy only in IDLE with key memory loaded; pt_vld/pt_data held until pt_rdy.
module simon128_256_decrypt
  import simon_pkg::*;
#(
  parameter int ROUNDS         = SIMON128_256_ROUNDS,
  parameter int KEY_BASE       = 0,
  parameter int KEY_ADDR_WIDTH = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [127:0]              ct_data,
  input  logic                      ct_vld,
  output logic                      ct_rdy,
  output logic [127:0]              pt_data,
  output logic                      pt_vld,
  input  logic                      pt_rdy,
  input  logic                      key_mem_full,
  output logic                      key_rd_en,
  output logic [KEY_ADDR_WIDTH-1:0] key_addr,
  input  logic                      key_data_vld,
  input  logic [SIMON_WORD-1:0]     key_data
);

  localparam logic [6:0] ROUNDS_W = 7'(ROUNDS);
  localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

  simon_dec_state_t      state_q, state_d;
  logic [SIMON_WORD-1:0] x_q, x_d, y_q, y_d;
  logic [6:0]            rd_idx_q, rd_idx_d;   // next key index to fetch
  logic [6:0]            rnd_cnt_q, rnd_cnt_d; // rounds applied so far
  logic [6:0]            rd_cnt_q, rd_cnt_d;   // reads issued so far
  logic                  out_q, out_d;         // a key read is outstanding
  logic                  issue;
  logic [SIMON_WORD-1:0] x_rnd, y_rnd;

  simon128_dec_round u_round (
    .x      (x_q),
    .y      (y_q),
    .k      (key_data),
    .x_next (x_rnd),
    .y_next (y_rnd)
  );

  // Next-state, key-read issue and stream handshakes
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    rd_idx_d  = rd_idx_q;
    rnd_cnt_d = rnd_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    out_d     = out_q;
    issue     = 1'b0;
    ct_rdy    = 1'b0;
    pt_vld    = 1'b0;
    pt_data   = '0;
    key_rd_en = 1'b0;
    key_addr  = '0;
    case (state_q)
      IDLE: begin
        // Held low while reset is asserted so nothing is offered mid-reset.
        ct_rdy = key_mem_full & ~rst;
        if (ct_vld && ct_rdy) begin
          x_d       = ct_data[127:64];
          y_d       = ct_data[63:0];
          rd_idx_d  = LAST_IDX;
          rnd_cnt_d = '0;
          rd_cnt_d  = '0;
          out_d     = 1'b0;
          state_d   = RUN;
        end
      end
      RUN: begin
        // A return this cycle frees the single read slot, so the next read
        // can go out in the same cycle and a 1-cycle memory streams keys.
        issue = (~out_q | key_data_vld) & (rd_cnt_q < ROUNDS_W);
        if (issue) begin
          key_rd_en = 1'b1;
          key_addr  = KEY_ADDR_WIDTH'(KEY_BASE) + KEY_ADDR_WIDTH'(rd_idx_q);
          rd_cnt_d  = rd_cnt_q + 7'd1;
          if (rd_idx_q != 7'd0) rd_idx_d = rd_idx_q - 7'd1;
        end
        out_d = issue | (out_q & ~key_data_vld);
        if (key_data_vld) begin
          x_d       = x_rnd;
          y_d       = y_rnd;
          rnd_cnt_d = rnd_cnt_q + 7'd1;
          if (rnd_cnt_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE: begin
        pt_vld  = 1'b1;
        pt_data = {x_q, y_q};
        if (pt_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, block and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      rd_idx_q  <= '0;
      rnd_cnt_q <= '0;
      rd_cnt_q  <= '0;
      out_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rd_idx_q  <= rd_idx_d;
      rnd_cnt_q <= rnd_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      out_q     <= out_d;
    end
  end

endmodule
